qpsk_symbol_deframer: RTL
=========================

QPSK_SYMBOL_DEFRAMER -- requirements
Module: qpsk_symbol_deframer

Interface
REQ-001 Parameter SPS, default 16, number of input samples per symbol; SHALL be even and at least 4.
REQ-002 Parameter SYNC_WORD, default 16'hD391, 8-symbol sync pattern, first symbol in bits [15:14].
REQ-003 Parameter FRAME_BYTES, default 32, payload bytes per frame, range 1..255.
REQ-004 clk  in  1  single clock for all logic.
REQ-005 reset_n  in  1  asynchronous, active-low reset.
REQ-006 symbol_in  in  2  demodulator slicer output, one sample per valid cycle.
REQ-007 symbol_in_valid  in  1  symbol_in carries a sample this cycle.
REQ-008 byte_out  out  8  deframed payload byte.
REQ-009 byte_valid  out  1  byte_out holds an unconsumed byte.
REQ-010 byte_last  out  1  byte_out is the final byte of its frame; qualified by byte_valid.
REQ-011 byte_ready  in  1  consumer accepts byte_out when high with byte_valid.
REQ-012 frame_locked  out  1  high while in PAYLOAD state.
REQ-013 overflow  out  1  sticky flag: a completed byte was dropped.
REQ-014 overflow_clr  in  1  synchronous clear of overflow.

Function
REQ-015 Phase counter (width clog2(SPS)) SHALL update only on cycles with symbol_in_valid high; otherwise all state holds.
REQ-016 On a valid sample differing from the last valid sample, phase SHALL load 0; otherwise phase SHALL increment, wrapping SPS-1 -> 0.
REQ-017 A symbol strobe SHALL fire on the valid sample whose updated phase equals SPS/2; that sample's symbol_in is the decided symbol.
REQ-018 States SHALL be HUNT and PAYLOAD; reset state is HUNT.
REQ-019 HUNT: each decided symbol shifts into a 16-bit register at bits [1:0]; when the register after the shift equals SYNC_WORD, move to PAYLOAD next cycle with symbol and byte counters at 0.
REQ-020 PAYLOAD: decided symbols pack MSB-first; the first symbol of a byte occupies byte[7:6].
REQ-021 On the 4th symbol of a byte, byte_out/byte_valid SHALL register on the next clock edge (latency 1 cycle from the strobe).
REQ-022 byte_valid SHALL stay high, and byte_out/byte_last stable, until a cycle with byte_ready high; byte_valid deasserts on the following edge unless a new byte is loaded on that same edge.
REQ-023 A byte completing while the held byte is not accepted in that same cycle SHALL be dropped and overflow set; byte and frame counters still advance.
REQ-024 byte_last SHALL be high for byte index FRAME_BYTES-1; after that byte completes, state returns to HUNT and the sync shift register clears to 0.
REQ-025 The sync shift register SHALL NOT be updated during PAYLOAD; sync words inside payload are ignored.
REQ-026 overflow_clr high SHALL clear overflow unless a drop occurs in the same cycle (set wins).

Reset
REQ-027 reset_n low SHALL asynchronously force: state HUNT, phase 0, last-sample 2'b00, shift register 0, counters 0, byte_out 8'h00, byte_valid 0, byte_last 0, frame_locked 0, overflow 0.
REQ-028 Reset mid-frame SHALL discard the partial byte and any held byte; no byte_valid until a new SYNC_WORD is detected.

Structure
REQ-029 State encoding enum and default SPS/SYNC_WORD/FRAME_BYTES constants SHALL live in the shared modem package.
REQ-030 Timing recovery (REQ-015..017) SHALL be a sub-module qpsk_symbol_sampler with outputs sym and sym_strobe.

Verification
REQ-031 SPS=16, symbols held 16 samples each, sequence of SYNC_WORD then 0xA5 and 0x3C with FRAME_BYTES=2 -> bytes 8'hA5, then 8'h3C with byte_last=1; frame_locked falls after second byte.
REQ-032 Same stream with symbol_in_valid low every other cycle -> identical byte sequence, strobes at half rate.
REQ-033 Sync word with one symbol flipped -> frame_locked stays 0, no byte_valid.
REQ-034 byte_ready held low through 2 completed bytes -> first byte held stable, second dropped, overflow=1; overflow_clr pulse -> overflow=0.
REQ-035 reset_n pulsed low after 2 payload symbols -> all outputs at reset values immediately; following complete frame decodes correctly.
REQ-036 Stream with initial 5-sample phase offset -> strobe lands on sample 8 after each transition; decoded bytes correct.

Source files
------------

// File: rtl/qpsk_symbol_deframer_pkg.sv
// Shared modem constants and state encoding for the QPSK symbol deframer.
// Default parameters, FSM state enum and a byte-assembly helper.
package qpsk_symbol_deframer_pkg;

    localparam int          DEF_SPS         = 16;
    localparam logic [15:0] DEF_SYNC_WORD   = 16'hD391;
    localparam int          DEF_FRAME_BYTES = 32;

    typedef enum logic {
        ST_HUNT    = 1'b0,
        ST_PAYLOAD = 1'b1
    } deframer_state_e;

    // Three earlier symbols (MSB-first) plus the closing symbol form a byte.
    function automatic logic [7:0] pack_byte(input logic [5:0] acc, input logic [1:0] sym);
        return {acc, sym};
    endfunction

endpackage

// File: rtl/qpsk_symbol_deframer_sampler.sv
// Symbol timing recovery: re-aligns phase on every sample transition and
// strobes the decided symbol at mid-symbol.
module qpsk_symbol_sampler
    import qpsk_symbol_deframer_pkg::*;
#(
    parameter int SPS = DEF_SPS
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] symbol_in,
    input  logic       symbol_in_valid,
    output logic [1:0] sym,
    output logic       sym_strobe
);

    localparam int            PW        = $clog2(SPS);
    localparam logic [PW-1:0] PHASE_MAX = PW'(SPS - 1);
    localparam logic [PW-1:0] PHASE_MID = PW'(SPS / 2);

    logic [PW-1:0] phase_q, phase_d;
    logic [1:0]    last_q,  last_d;

    always_comb begin
        phase_d = phase_q;
        last_d  = last_q;
        if (symbol_in_valid) begin
            last_d = symbol_in;
            if (symbol_in != last_q) begin
                phase_d = '0;
            end else if (phase_q == PHASE_MAX) begin
                phase_d = '0;
            end else begin
                phase_d = phase_q + PW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            phase_q <= '0;
            last_q  <= 2'b00;
        end else begin
            phase_q <= phase_d;
            last_q  <= last_d;
        end
    end

    // The strobe looks at the updated phase so it fires on the deciding sample itself.
    assign sym        = symbol_in;
    assign sym_strobe = symbol_in_valid && (phase_d == PHASE_MID);

endmodule

// File: rtl/qpsk_symbol_deframer.sv
// QPSK deframer: hunts for the sync word, then packs payload symbols into
// bytes behind a one-deep valid/ready output register.
module qpsk_symbol_deframer
    import qpsk_symbol_deframer_pkg::*;
#(
    parameter int          SPS         = DEF_SPS,
    parameter logic [15:0] SYNC_WORD   = DEF_SYNC_WORD,
    parameter int          FRAME_BYTES = DEF_FRAME_BYTES
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [1:0] symbol_in,
    input  logic       symbol_in_valid,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       byte_last,
    input  logic       byte_ready,
    output logic       frame_locked,
    output logic       overflow,
    input  logic       overflow_clr
);

    localparam logic [7:0] LAST_IDX = 8'(FRAME_BYTES - 1);

    logic [1:0] sym;
    logic       sym_strobe;

    qpsk_symbol_sampler #(.SPS(SPS)) u_sampler (
        .clk             (clk),
        .reset_n         (reset_n),
        .symbol_in       (symbol_in),
        .symbol_in_valid (symbol_in_valid),
        .sym             (sym),
        .sym_strobe      (sym_strobe)
    );

    deframer_state_e state_q, state_d;
    logic [15:0]     shift_q, shift_d;
    logic [1:0]      sym_cnt_q, sym_cnt_d;
    logic [7:0]      byte_cnt_q, byte_cnt_d;
    logic [5:0]      acc_q, acc_d;
    logic [7:0]      byte_out_q, byte_out_d;
    logic            byte_valid_q, byte_valid_d;
    logic            byte_last_q, byte_last_d;
    logic            overflow_q, overflow_d;

    logic            byte_done;
    logic            done_last;
    logic [7:0]      done_byte;
    logic            accept;
    logic            drop;

    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        sym_cnt_d    = sym_cnt_q;
        byte_cnt_d   = byte_cnt_q;
        acc_d        = acc_q;
        byte_out_d   = byte_out_q;
        byte_valid_d = byte_valid_q;
        byte_last_d  = byte_last_q;
        overflow_d   = overflow_q;
        byte_done    = 1'b0;
        done_last    = 1'b0;
        done_byte    = 8'h00;
        accept       = byte_valid_q && byte_ready;
        drop         = 1'b0;

        case (state_q)
            ST_HUNT: begin
                if (sym_strobe) begin
                    shift_d = {shift_q[13:0], sym};
                    if (shift_d == SYNC_WORD) begin
                        state_d    = ST_PAYLOAD;
                        sym_cnt_d  = 2'd0;
                        byte_cnt_d = 8'd0;
                        acc_d      = 6'd0;
                    end
                end
            end
            ST_PAYLOAD: begin
                if (sym_strobe) begin
                    if (sym_cnt_q == 2'd3) begin
                        byte_done = 1'b1;
                        done_byte = pack_byte(acc_q, sym);
                        done_last = (byte_cnt_q == LAST_IDX);
                        sym_cnt_d = 2'd0;
                        if (done_last) begin
                            state_d    = ST_HUNT;
                            shift_d    = 16'h0000;
                            byte_cnt_d = 8'd0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 8'd1;
                        end
                    end else begin
                        acc_d     = {acc_q[3:0], sym};
                        sym_cnt_d = sym_cnt_q + 2'd1;
                    end
                end
            end
            default: state_d = ST_HUNT;
        endcase

        // A finished byte may replace the held one only if it is leaving this cycle.
        if (byte_done && (!byte_valid_q || accept)) begin
            byte_out_d   = done_byte;
            byte_last_d  = done_last;
            byte_valid_d = 1'b1;
        end else begin
            if (accept) begin
                byte_valid_d = 1'b0;
            end
            drop = byte_done;
        end

        if (drop) begin
            overflow_d = 1'b1;
        end else if (overflow_clr) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_HUNT;
            shift_q      <= 16'h0000;
            sym_cnt_q    <= 2'd0;
            byte_cnt_q   <= 8'd0;
            acc_q        <= 6'd0;
            byte_out_q   <= 8'h00;
            byte_valid_q <= 1'b0;
            byte_last_q  <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            shift_q      <= shift_d;
            sym_cnt_q    <= sym_cnt_d;
            byte_cnt_q   <= byte_cnt_d;
            acc_q        <= acc_d;
            byte_out_q   <= byte_out_d;
            byte_valid_q <= byte_valid_d;
            byte_last_q  <= byte_last_d;
            overflow_q   <= overflow_d;
        end
    end

    assign byte_out     = byte_out_q;
    assign byte_valid   = byte_valid_q;
    assign byte_last    = byte_last_q;
    assign overflow     = overflow_q;
    assign frame_locked = (state_q == ST_PAYLOAD);

endmodule
